// File: rtl/covox_mixer_sd.sv
`timescale 1ns/1ps
// Soundrive/Covox stereo mixer: four 8-bit channels plus beeper summed into
// 10-bit PCM once per DIV clocks, with a first-order sigma-delta bit per side.
//
// state  | meaning
// IDLE   | waiting for the sample-period tick
// S_AC   | load acc_l/acc_r from channels A/C
// S_BD   | add channels B/D
// S_BEEP | add BEEP_LVL to both sides when the beeper is high
// S_OUT  | saturate to 10 bits, publish pcm_l/pcm_r and pulse pcm_stb
module covox_mixer_sd #(
    parameter int unsigned DIV      = 8,
    parameter logic [9:0]  BEEP_LVL = 10'd128
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ena,
    input  logic [7:0] ina,
    input  logic [7:0] inb,
    input  logic [7:0] inc,
    input  logic [7:0] ind,
    input  logic       beeper,
    output logic [9:0] pcm_l,
    output logic [9:0] pcm_r,
    output logic       pcm_stb,
    output logic       dac_l,
    output logic       dac_r
);

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_AC   = 3'd1,
        S_BD   = 3'd2,
        S_BEEP = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] div_cnt;
    logic        tick;
    logic [10:0] acc_l;
    logic [10:0] acc_r;
    logic [10:0] sd_l;
    logic [10:0] sd_r;

    assign tick = (div_cnt == DIV_LAST);

    function automatic logic [9:0] sat10(input logic [10:0] v);
        return v[10] ? 10'd1023 : v[9:0];
    endfunction

    // A dropped enable abandons any sample in flight; the PCM outputs keep
    // the last completed sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            state   <= IDLE;
            acc_l   <= '0;
            acc_r   <= '0;
            pcm_l   <= '0;
            pcm_r   <= '0;
            pcm_stb <= 1'b0;
        end else if (!ena) begin
            div_cnt <= '0;
            state   <= IDLE;
            pcm_stb <= 1'b0;
        end else begin
            pcm_stb <= 1'b0;
            div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (tick) state <= S_AC;
                end
                S_AC: begin
                    acc_l <= {3'b000, ina};
                    acc_r <= {3'b000, inc};
                    state <= S_BD;
                end
                S_BD: begin
                    acc_l <= acc_l + {3'b000, inb};
                    acc_r <= acc_r + {3'b000, ind};
                    state <= S_BEEP;
                end
                S_BEEP: begin
                    if (beeper) begin
                        acc_l <= acc_l + {1'b0, BEEP_LVL};
                        acc_r <= acc_r + {1'b0, BEEP_LVL};
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    pcm_l   <= sat10(acc_l);
                    pcm_r   <= sat10(acc_r);
                    pcm_stb <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accumulator keeps the 10-bit residue; bit 10 is the carry, which is
    // re-registered into the pin so the DAC output has a clean flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_l  <= '0;
            sd_r  <= '0;
            dac_l <= 1'b0;
            dac_r <= 1'b0;
        end else if (!ena) begin
            sd_l  <= '0;
            sd_r  <= '0;
            dac_l <= 1'b0;
            dac_r <= 1'b0;
        end else begin
            sd_l  <= {1'b0, sd_l[9:0]} + {1'b0, pcm_l};
            sd_r  <= {1'b0, sd_r[9:0]} + {1'b0, pcm_r};
            dac_l <= sd_l[10];
            dac_r <= sd_r[10];
        end
    end

endmodule

// File: tb/tb_covox_mixer_sd.sv
`timescale 1ns/1ps
// Self-checking bench for covox_mixer_sd: per-cycle reference model of sample
// timing and mix values, plus directed mix, saturation, density and enable cases.
module tb_covox_mixer_sd;

    localparam int DIV   = 8;
    localparam int BEEP1 = 128;
    localparam int BEEP2 = 600;
    localparam int NH    = 16384;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       ena = 1'b0;
    logic       beeper = 1'b0;
    logic [7:0] ina = '0, inb = '0, inc = '0, ind = '0;

    logic [9:0] pcm_l, pcm_r, pcm2_l, pcm2_r;
    logic       pcm_stb, pcm2_stb, dac_l, dac_r, dac2_l, dac2_r;

    covox_mixer_sd #(.DIV(DIV), .BEEP_LVL(10'(BEEP1))) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena),
        .ina(ina), .inb(inb), .inc(inc), .ind(ind), .beeper(beeper),
        .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_stb(pcm_stb),
        .dac_l(dac_l), .dac_r(dac_r)
    );

    covox_mixer_sd #(.DIV(DIV), .BEEP_LVL(10'(BEEP2))) dut2 (
        .clk(clk), .reset_n(reset_n), .ena(ena),
        .ina(ina), .inb(inb), .inc(inc), .ind(ind), .beeper(beeper),
        .pcm_l(pcm2_l), .pcm_r(pcm2_r), .pcm_stb(pcm2_stb),
        .dac_l(dac2_l), .dac_r(dac2_r)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int run_start = -1000000;
    bit prev_act = 1'b0;

    logic [7:0] ha[NH], hb[NH], hc[NH], hd[NH];
    bit         hbp[NH], hact[NH];
    int exp_l = 0, exp_r = 0, exp2_l = 0, exp2_r = 0;

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: a sample appears DIV+4 clocks after the enable run starts and
    // every DIV clocks after; A/C are taken 4 clocks before it is visible,
    // B/D 3 clocks before and the beeper 2 clocks before.
    task automatic check_cycle();
        int n;
        bit es;
        n  = cyc;
        es = hact[n-1] && (n - run_start >= DIV + 4) && ((n - run_start - DIV - 4) % DIV == 0);
        if (es) begin
            exp_l  = sat(int'(ha[n-4]) + int'(hb[n-3]) + (hbp[n-2] ? BEEP1 : 0));
            exp_r  = sat(int'(hc[n-4]) + int'(hd[n-3]) + (hbp[n-2] ? BEEP1 : 0));
            exp2_l = sat(int'(ha[n-4]) + int'(hb[n-3]) + (hbp[n-2] ? BEEP2 : 0));
            exp2_r = sat(int'(hc[n-4]) + int'(hd[n-3]) + (hbp[n-2] ? BEEP2 : 0));
        end
        chk("pcm_stb", 32'(pcm_stb), 32'(es));
        chk("pcm2_stb", 32'(pcm2_stb), 32'(es));
        chk("pcm_l", 32'(pcm_l), exp_l);
        chk("pcm_r", 32'(pcm_r), exp_r);
        chk("pcm2_l", 32'(pcm2_l), exp2_l);
        chk("pcm2_r", 32'(pcm2_r), exp2_r);
        if (!hact[n-1]) begin
            chk("dac_idle", {30'd0, dac_l, dac_r}, 32'd0);
            chk("dac2_idle", {30'd0, dac2_l, dac2_r}, 32'd0);
        end
    endtask

    task automatic step();
        ha[cyc]   = ina;
        hb[cyc]   = inb;
        hc[cyc]   = inc;
        hd[cyc]   = ind;
        hbp[cyc]  = beeper;
        hact[cyc] = ena && reset_n;
        if (hact[cyc] && !prev_act) run_start = cyc;
        prev_act = hact[cyc];
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= NH - 1) begin
            $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, NH - 1);
            $fatal(1, "cycle budget exhausted");
        end
        check_cycle();
    endtask

    task automatic wait_stb();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!pcm_stb && k < 3 * DIV);
        chk("stb_wait", 32'(pcm_stb), 32'd1);
    endtask

    function automatic int next_phase(input int off);
        int t;
        t = cyc + 1;
        while ((t - run_start < off) || ((t - run_start - off) % DIV != 0)) t++;
        return t;
    endfunction

    task automatic go_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic count_window(output int ones_l, output int ones_r,
                                output int ones2_l, output int ones2_r);
        ones_l = 0; ones_r = 0; ones2_l = 0; ones2_r = 0;
        for (int i = 0; i < 1024; i++) begin
            step();
            ones_l  += int'(dac_l);
            ones_r  += int'(dac_r);
            ones2_l += int'(dac2_l);
            ones2_r += int'(dac2_r);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {9'd0, pcm_l, pcm_r, pcm_stb, dac_l, dac_r}, 32'd0);
        chk(tag, {9'd0, pcm2_l, pcm2_r, pcm2_stb, dac2_l, dac2_r}, 32'd0);
    endtask

    initial begin
        int o_l, o_r, o2_l, o2_r, nstb;

        // Reset with random inputs
        ena = 1'b1;
        ina = 8'($urandom); inb = 8'($urandom); inc = 8'($urandom); ind = 8'($urandom);
        beeper = 1'($urandom);
        #1 reset_n = 1'b0;
        #1 check_all_zero("reset_async");
        repeat (4) begin
            ina = 8'($urandom); inb = 8'($urandom); inc = 8'($urandom); ind = 8'($urandom);
            beeper = 1'($urandom);
            step();
        end

        // Basic mix
        reset_n = 1'b1;
        ina = 8'h10; inb = 8'h20; inc = 8'h40; ind = 8'h80; beeper = 1'b0;
        nstb = 0;
        repeat (DIV + 3) begin
            step();
            nstb += int'(pcm_stb);
        end
        chk("no_stb_after_release", nstb, 0);
        step();
        chk("first_stb", 32'(pcm_stb), 32'd1);
        chk("basic_l", 32'(pcm_l), 32'd48);
        chk("basic_r", 32'(pcm_r), 32'd192);
        repeat (DIV - 1) step();
        chk("stb_gap", 32'(pcm_stb), 32'd0);
        step();
        chk("stb_period", 32'(pcm_stb), 32'd1);

        // Beeper and saturation
        ina = 8'hFF; inb = 8'hFF; inc = 8'hFF; ind = 8'hFF; beeper = 1'b1;
        wait_stb();
        wait_stb();
        chk("beep_l", 32'(pcm_l), 32'd638);
        chk("beep_r", 32'(pcm_r), 32'd638);
        chk("sat_l", 32'(pcm2_l), 32'd1023);
        chk("sat_r", 32'(pcm2_r), 32'd1023);

        // Sigma-delta density at 256 / 0
        ina = 8'd128; inb = 8'd128; inc = 8'd0; ind = 8'd0; beeper = 1'b0;
        wait_stb();
        wait_stb();
        repeat (4) step();
        count_window(o_l, o_r, o2_l, o2_r);
        chk("density_256", o_l, 256);
        chk("density_0", o_r, 0);
        chk("density2_256", o2_l, 256);

        // Density at 638 and full scale
        ina = 8'hFF; inb = 8'hFF; inc = 8'hFF; ind = 8'hFF; beeper = 1'b1;
        wait_stb();
        wait_stb();
        repeat (4) step();
        count_window(o_l, o_r, o2_l, o2_r);
        chk("density_638", o_l, 638);
        chk("density_1023_l_zeros", 1024 - o2_l, 1);
        chk("density_1023_r_zeros", 1024 - o2_r, 1);

        // Enable drop during S_BD
        wait_stb();
        ina = 8'd1; inb = 8'd2; inc = 8'd3; ind = 8'd4; beeper = 1'b0;
        go_to(next_phase(DIV + 1));
        ena = 1'b0;
        step();
        chk("drop_dac", {30'd0, dac_l, dac_r}, 32'd0);
        nstb = 0;
        repeat (DIV + 4) begin
            step();
            nstb += int'(pcm_stb);
        end
        chk("drop_no_stb", nstb, 0);
        chk("drop_hold_l", 32'(pcm_l), 32'd638);
        ena = 1'b1;
        nstb = 0;
        repeat (DIV + 3) begin
            step();
            nstb += int'(pcm_stb);
        end
        chk("reen_no_early_stb", nstb, 0);
        step();
        chk("reen_stb", 32'(pcm_stb), 32'd1);
        chk("reen_l", 32'(pcm_l), 32'd3);
        chk("reen_r", 32'(pcm_r), 32'd7);

        // Mid-sequence input changes
        ina = 8'd16; inb = 8'd16; inc = 8'd0; ind = 8'd0;
        wait_stb();
        go_to(next_phase(DIV));
        inb = 8'd48;
        wait_stb();
        chk("inb_in_sac", 32'(pcm_l), 32'd64);
        go_to(next_phase(DIV + 2));
        inb = 8'd80;
        wait_stb();
        chk("inb_in_sbeep_old", 32'(pcm_l), 32'd64);
        wait_stb();
        chk("inb_in_sbeep_new", 32'(pcm_l), 32'd96);
        go_to(next_phase(DIV + 1));
        inb = 8'd100; ind = 8'd50;
        wait_stb();
        chk("bd_same_l", 32'(pcm_l), 32'd116);
        chk("bd_same_r", 32'(pcm_r), 32'd50);

        // Asynchronous reset mid-sequence
        go_to(next_phase(DIV + 2));
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset_mid");
        exp_l = 0; exp_r = 0; exp2_l = 0; exp2_r = 0;
        repeat (3) step();
        reset_n = 1'b1;
        nstb = 0;
        repeat (DIV + 3) begin
            step();
            nstb += int'(pcm_stb);
        end
        chk("reset_mid_no_stb", nstb, 0);
        step();
        chk("reset_mid_first_stb", 32'(pcm_stb), 32'd1);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 1500; i++) begin
            ina = 8'($urandom); inb = 8'($urandom);
            inc = 8'($urandom); ind = 8'($urandom);
            beeper = 1'($urandom);
            if ($urandom_range(0, 63) == 0) ena = ~ena;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
